// File: rtl/sent_tx_pulse_gen_p.sv
// SENT transmitter pulse generator: turns SYNC/NIBBLE/PAUSE commands into the SENT line waveform.
// Optional macro SENT_TX_FIXED_FRAME_EN sizes the PAUSE pulse so every frame totals FRAME_TICKS.
module sent_tx_pulse_gen_p #(
    parameter int unsigned LOW_TICKS   = 5,
    parameter int unsigned SYNC_TICKS  = 56,
    parameter int unsigned NIBBLE_BASE = 12,
    parameter int unsigned FRAME_TICKS = 282,
    parameter int unsigned PAUSE_MIN   = 12,
    parameter int unsigned PAUSE_TICKS = 77,
    parameter int unsigned CNT_W       = 10
) (
    input  logic             ticks,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_type,
    input  logic [3:0]       data_nibble,
    output logic             cmd_ready,
    output logic             data_pulse,
    output logic             pulse_done,
    output logic [CNT_W-1:0] frame_ticks,
    output logic             frame_err,
    output logic             cmd_err
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_PULSE = 1'b1
    } state_t;

    localparam logic [1:0] CMD_SYNC   = 2'd0;
    localparam logic [1:0] CMD_NIBBLE = 2'd1;
    localparam logic [1:0] CMD_PAUSE  = 2'd2;

    localparam logic [CNT_W-1:0] LOW_C    = CNT_W'(LOW_TICKS);
    localparam logic [CNT_W-1:0] SYNC_C   = CNT_W'(SYNC_TICKS);
    localparam logic [CNT_W-1:0] NIBBLE_C = CNT_W'(NIBBLE_BASE);
`ifdef SENT_TX_FIXED_FRAME_EN
    localparam logic [CNT_W-1:0] FRAME_C  = CNT_W'(FRAME_TICKS);
    localparam logic [CNT_W-1:0] PMIN_C   = CNT_W'(PAUSE_MIN);
`else
    localparam logic [CNT_W-1:0] PAUSE_C  = CNT_W'(PAUSE_TICKS);
`endif

    // Reject parameter sets whose pulses cannot be represented in CNT_W bits.
    localparam bit CFG_OK = (LOW_TICKS >= 1) && (LOW_TICKS < NIBBLE_BASE) &&
                            (SYNC_TICKS >= 1) && (PAUSE_MIN >= 1) && (PAUSE_TICKS >= 1) &&
                            (CNT_W >= 2) && (CNT_W < 32) &&
                            ((FRAME_TICKS >> CNT_W) == 32'd0) &&
                            ((SYNC_TICKS >> CNT_W) == 32'd0) &&
                            ((PAUSE_TICKS >> CNT_W) == 32'd0) &&
                            (((NIBBLE_BASE + 15) >> CNT_W) == 32'd0);

    if (!CFG_OK) begin : g_cfg_err
        $error("sent_tx_pulse_gen_p: invalid parameter set");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] frame_d;
    logic [CNT_W-1:0] frame_base;
    logic [CNT_W-1:0] nib_len;
    logic [CNT_W:0]   nib_sum;
    logic [CNT_W-1:0] pause_len;
    logic [CNT_W-1:0] pulse_len;
`ifdef SENT_TX_FIXED_FRAME_EN
    logic [CNT_W-1:0] pause_gap;
`endif
    logic             pause_q, pause_d;
    logic             done_pend_q;
    logic             last;
    logic             accept;
    logic             start;
    logic             pause_clamp;
    logic             data_pulse_d;
    logic             frame_err_d;
    logic             cmd_err_d;

    // Next-state, pulse length selection and frame accumulator update.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        pause_d      = pause_q;
        frame_d      = frame_ticks;
        frame_err_d  = 1'b0;
        cmd_err_d    = 1'b0;
        start        = 1'b0;
        pulse_len    = '0;

        // cnt_q runs 1..len_q over the pulse; the line is low while cnt_q <= LOW_C.
        last         = (state_q == S_PULSE) && (cnt_q == len_q);
        cmd_ready    = (state_q == S_IDLE) || last;
        accept       = cmd_valid && cmd_ready;
        data_pulse_d = (state_q == S_PULSE) ? (cnt_q > LOW_C) : 1'b1;

        // A completing pause clears the frame, even if a command is accepted on the same edge.
        frame_base   = (last && pause_q) ? '0 : frame_ticks;
        nib_len      = NIBBLE_C + CNT_W'(data_nibble);
        nib_sum      = {1'b0, frame_base} + {1'b0, nib_len};

`ifdef SENT_TX_FIXED_FRAME_EN
        pause_gap    = FRAME_C - frame_base;
        pause_clamp  = (frame_base > FRAME_C) || (pause_gap < PMIN_C);
        pause_len    = pause_clamp ? PMIN_C : pause_gap;
`else
        pause_clamp  = 1'b0;
        pause_len    = PAUSE_C;
`endif

        if (state_q == S_PULSE) begin
            if (last) begin
                state_d = S_IDLE;
                frame_d = frame_base;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (accept) begin
            case (cmd_type)
                CMD_SYNC: begin
                    start     = 1'b1;
                    pulse_len = SYNC_C;
                    frame_d   = SYNC_C;
                    pause_d   = 1'b0;
                end
                CMD_NIBBLE: begin
                    start     = 1'b1;
                    pulse_len = nib_len;
                    frame_d   = nib_sum[CNT_W] ? '1 : nib_sum[CNT_W-1:0];
                    pause_d   = 1'b0;
                end
                CMD_PAUSE: begin
                    start       = 1'b1;
                    pulse_len   = pause_len;
                    frame_d     = frame_base;
                    frame_err_d = pause_clamp;
                    pause_d     = 1'b1;
                end
                default: begin
                    cmd_err_d = 1'b1;
                end
            endcase
        end

        if (start) begin
            state_d = S_PULSE;
            len_d   = pulse_len;
            cnt_d   = CNT_W'(1);
        end
    end

    // State and registered outputs; pulse_done trails the last pulse tick by one cycle.
    always_ff @(posedge ticks or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            pause_q     <= 1'b0;
            done_pend_q <= 1'b0;
            data_pulse  <= 1'b1;
            pulse_done  <= 1'b0;
            frame_ticks <= '0;
            frame_err   <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            pause_q     <= pause_d;
            done_pend_q <= last;
            data_pulse  <= data_pulse_d;
            pulse_done  <= done_pend_q;
            frame_ticks <= frame_d;
            frame_err   <= frame_err_d;
            cmd_err     <= cmd_err_d;
        end
    end

endmodule

// File: tb/tb_sent_tx_pulse_gen_p.sv
// Directed bench for sent_tx_pulse_gen_p; expectations follow SENT_TX_FIXED_FRAME_EN when defined.
module tb_sent_tx_pulse_gen_p;

    localparam int unsigned CNT_W = 10;

`ifdef SENT_TX_FIXED_FRAME_EN
    localparam int PAUSE_A   = 124;
    localparam int PAUSE_B   = 12;
    localparam int FERR_B    = 1;
    localparam int FRAME_A   = 282;
`else
    localparam int PAUSE_A   = 77;
    localparam int PAUSE_B   = 77;
    localparam int FERR_B    = 0;
    localparam int FRAME_A   = 235;
`endif

    logic             ticks;
    logic             reset;
    logic             cmd_valid;
    logic [1:0]       cmd_type;
    logic [3:0]       data_nibble;
    logic             cmd_ready;
    logic             data_pulse;
    logic             pulse_done;
    logic [CNT_W-1:0] frame_ticks;
    logic             frame_err;
    logic             cmd_err;

    int n_checks = 0;
    int n_errors = 0;

    sent_tx_pulse_gen_p dut (
        .ticks       (ticks),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_type    (cmd_type),
        .data_nibble (data_nibble),
        .cmd_ready   (cmd_ready),
        .data_pulse  (data_pulse),
        .pulse_done  (pulse_done),
        .frame_ticks (frame_ticks),
        .frame_err   (frame_err),
        .cmd_err     (cmd_err)
    );

    initial ticks = 1'b0;
    always #5 ticks = ~ticks;

    task automatic tick();
        @(posedge ticks);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one command from IDLE and wait (bounded) for its pulse_done strobe.
    task automatic send_wait(input logic [1:0] t, input logic [3:0] nib, output int len,
                             output int lows, output logic [CNT_W-1:0] acc_frame,
                             output logic acc_ferr, output int ferr_cnt);
        cmd_valid   = 1'b1;
        cmd_type    = t;
        data_nibble = nib;
        tick();
        cmd_valid = 1'b0;
        acc_frame = frame_ticks;
        acc_ferr  = frame_err;
        len       = 0;
        lows      = 0;
        ferr_cnt  = 0;
        while (!pulse_done && len < 400) begin
            tick();
            len++;
            if (!data_pulse) lows++;
            if (frame_err) ferr_cnt++;
        end
        len = len - 1;
        chk("pulse_done_seen", 32'(pulse_done), 1);
    endtask

    int               len;
    int               lows;
    int               ferr_cnt;
    int               total;
    logic [CNT_W-1:0] acc_frame;
    logic             acc_ferr;

    initial begin
        reset       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_type    = 2'd0;
        data_nibble = 4'd0;

        // Reset state
        #12;
        chk("rst_data_pulse", 32'(data_pulse), 1);
        chk("rst_pulse_done", 32'(pulse_done), 0);
        chk("rst_frame_ticks", 32'(frame_ticks), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_cmd_err", 32'(cmd_err), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        tick();

        // SYNC accepted at edge 1: low after edges 2..6, high 7..57, pulse_done after 58
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_type  = 2'd0;
        tick();
        cmd_valid = 1'b0;
        chk("sync_acc_frame", 32'(frame_ticks), 56);
        chk("sync_acc_line", 32'(data_pulse), 1);
        chk("sync_acc_ready", 32'(cmd_ready), 0);
        for (int e = 2; e <= 59; e++) begin
            tick();
            chk("sync_line", 32'(data_pulse), 32'(e >= 7));
            chk("sync_done", 32'(pulse_done), 32'(e == 58));
            chk("sync_ready", 32'(cmd_ready), 32'(e >= 56));
        end

        // Back-to-back NIBBLE 0 then 15: 12 + 27 ticks, no high gap between them
        cmd_valid   = 1'b1;
        cmd_type    = 2'd1;
        data_nibble = 4'd0;
        tick();
        chk("b2b_acc_frame", 32'(frame_ticks), 68);
        chk("b2b_acc_ready", 32'(cmd_ready), 0);
        data_nibble = 4'd15;
        for (int n = 1; n <= 40; n++) begin
            tick();
            chk("b2b_line", 32'(data_pulse), 32'(!((n <= 5) || (n >= 13 && n <= 17))));
            chk("b2b_done", 32'(pulse_done), 32'(n == 13 || n == 40));
            chk("b2b_ready", 32'(cmd_ready), 32'(n == 11 || n >= 38));
            if (n == 12) cmd_valid = 1'b0;
        end
        chk("b2b_frame", 32'(frame_ticks), 95);
        chk("b2b_cmd_err", 32'(cmd_err), 0);

        // SYNC + six NIBBLE 5 then PAUSE
        send_wait(2'd0, 4'd0, len, lows, acc_frame, acc_ferr, ferr_cnt);
        chk("fa_sync_len", 32'(len), 56);
        total = len;
        for (int i = 0; i < 6; i++) begin
            send_wait(2'd1, 4'd5, len, lows, acc_frame, acc_ferr, ferr_cnt);
            chk("fa_nib_len", 32'(len), 17);
            total += len;
        end
        chk("fa_frame_before_pause", 32'(frame_ticks), 158);
        send_wait(2'd2, 4'd0, len, lows, acc_frame, acc_ferr, ferr_cnt);
        chk("fa_pause_acc_frame", 32'(acc_frame), 158);
        chk("fa_pause_len", 32'(len), 32'(PAUSE_A));
        chk("fa_pause_ferr", 32'(acc_ferr), 0);
        chk("fa_pause_lows", 32'(lows), 5);
        total += len;
        chk("fa_total", 32'(total), 32'(FRAME_A));
        chk("fa_frame_after", 32'(frame_ticks), 0);

        // SYNC + eight NIBBLE 15 then PAUSE: clamped when fixed frame is on
        send_wait(2'd0, 4'd0, len, lows, acc_frame, acc_ferr, ferr_cnt);
        for (int i = 0; i < 8; i++) begin
            send_wait(2'd1, 4'd15, len, lows, acc_frame, acc_ferr, ferr_cnt);
            chk("fb_nib_len", 32'(len), 27);
        end
        chk("fb_frame_before_pause", 32'(frame_ticks), 272);
        send_wait(2'd2, 4'd0, len, lows, acc_frame, acc_ferr, ferr_cnt);
        chk("fb_pause_len", 32'(len), 32'(PAUSE_B));
        chk("fb_pause_ferr", 32'(acc_ferr), 32'(FERR_B));
        chk("fb_ferr_one_cycle", 32'(ferr_cnt), 0);
        chk("fb_frame_after", 32'(frame_ticks), 0);

        // Reset asserted three cycles into a SYNC
        cmd_valid = 1'b1;
        cmd_type  = 2'd0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_sync_low", 32'(data_pulse), 0);
        reset = 1'b0;
        #1;
        chk("mid_rst_line", 32'(data_pulse), 1);
        chk("mid_rst_frame", 32'(frame_ticks), 0);
        chk("mid_rst_ready", 32'(cmd_ready), 1);
        chk("mid_rst_done", 32'(pulse_done), 0);
        tick();
        reset = 1'b1;
        send_wait(2'd0, 4'd0, len, lows, acc_frame, acc_ferr, ferr_cnt);
        chk("post_rst_sync_len", 32'(len), 56);
        chk("post_rst_sync_lows", 32'(lows), 5);
        chk("post_rst_sync_frame", 32'(acc_frame), 56);

        // Reserved command in IDLE
        cmd_valid = 1'b1;
        cmd_type  = 2'd3;
        tick();
        cmd_valid = 1'b0;
        chk("rsv_cmd_err", 32'(cmd_err), 1);
        chk("rsv_line", 32'(data_pulse), 1);
        chk("rsv_ready", 32'(cmd_ready), 1);
        chk("rsv_frame", 32'(frame_ticks), 56);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("rsv_err_clear", 32'(cmd_err), 0);
            chk("rsv_no_done", 32'(pulse_done), 0);
            chk("rsv_line_high", 32'(data_pulse), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
